maze_walker: RTL

MAZE_WALKER -- requirements
Module: maze_walker

---
 rtl/maze_walker.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/maze_walker.sv
// Depth-first maze solver: walks a 2^COORD_W x 2^COORD_W grid from (0,0) to the far corner.
// It queries cells one at a time and keeps the accepted moves on a stack for replay.
// Latency: one state transition per cycle. A cell query is held until mem_valid arrives.
// Backpressure: the replay holds move steady while move_ready is low.
// Optional feature: define MAZE_WALKER_STEP_CNT_EN to add the 16-bit step_count output.
//   clk, rst                  : clock, synchronous active-high reset
//   start                     : begin a solve (accepted only when idle)
//   mem_rd, mem_x, mem_y      : cell query request and address
//   mem_valid, mem_wall       : query answer (wall=1 means blocked)
//   X, Y                      : current position
//   busy, done, fail          : status
//   move_valid, move, move_ready : path replay handshake
//   step_count                : forward + backtrack moves, saturating (optional)
module maze_walker #(
  parameter int COORD_W     = 4,
  parameter int STACK_DEPTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               mem_rd,
  output logic [COORD_W-1:0] mem_x,
  output logic [COORD_W-1:0] mem_y,
  input  logic               mem_valid,
  input  logic               mem_wall,
  output logic [COORD_W-1:0] X,
  output logic [COORD_W-1:0] Y,
  output logic               busy,
  output logic               done,
  output logic               fail,
  output logic               move_valid,
  output logic [1:0]         move,
  input  logic               move_ready
`ifdef MAZE_WALKER_STEP_CNT_EN
  ,
  output logic [15:0]        step_count
`endif
);

  localparam int SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = $clog2(STACK_DEPTH);
  localparam logic [COORD_W-1:0] CMAX = '1;
  localparam logic [COORD_W-1:0] ONE  = COORD_W'(1);

  typedef enum logic [2:0] {IDLE, PROBE, WAIT, BACK, REPLAY} state_t;

  state_t            state, state_n;
  logic [COORD_W-1:0] x_r, y_r, x_n, y_n;
  logic [2:0]        d_r, d_n;          // candidate direction; 4 means all tried
  logic [SP_W-1:0]   sp_r, sp_n;        // number of entries on the stack
  logic [SP_W-1:0]   rp_r, rp_n;        // replay read pointer
  logic              done_r, done_n, fail_r, fail_n;
  logic              push;
  logic [1:0]        stack [STACK_DEPTH];

  logic [1:0]        dir, top;
  logic [SP_W-1:0]   sp_m1;
  logic              off, skip, full, at_goal;
  logic [COORD_W-1:0] fwd_x, fwd_y, bk_x, bk_y;

  // Neighbour of (x,y) in direction d; only meaningful when the move stays on-grid.
  function automatic logic [2*COORD_W-1:0] next_cell(input logic [COORD_W-1:0] x,
                                                      input logic [COORD_W-1:0] y,
                                                      input logic [1:0] d);
    logic [COORD_W-1:0] nx, ny;
    nx = x;
    ny = y;
    case (d)
      2'd0:    nx = x + ONE;
      2'd1:    ny = y + ONE;
      2'd2:    ny = y - ONE;
      default: nx = x - ONE;
    endcase
    return {nx, ny};
  endfunction

  assign dir   = d_r[1:0];
  assign sp_m1 = sp_r - SP_W'(1);
  assign top   = stack[sp_m1[IDX_W-1:0]];
  assign full  = (sp_r == SP_W'(STACK_DEPTH));

  assign {fwd_x, fwd_y} = next_cell(x_r, y_r, dir);
  // The reverse of a stored direction is its bitwise inverse.
  assign {bk_x, bk_y}   = next_cell(x_r, y_r, ~top);
  assign at_goal        = (fwd_x == CMAX) && (fwd_y == CMAX);

  always_comb begin
    off = 1'b0;
    case (dir)
      2'd0:    off = (x_r == CMAX);
      2'd1:    off = (y_r == CMAX);
      2'd2:    off = (y_r == '0);
      default: off = (x_r == '0);
    endcase
  end

  // Never probe straight back into the cell we just came from.
  assign skip = off || ((sp_r != '0) && (dir == ~top));

  always_comb begin
    state_n = state;
    x_n     = x_r;
    y_n     = y_r;
    d_n     = d_r;
    sp_n    = sp_r;
    rp_n    = rp_r;
    done_n  = done_r;
    fail_n  = fail_r;
    push    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          x_n     = '0;
          y_n     = '0;
          sp_n    = '0;
          rp_n    = '0;
          d_n     = '0;
          done_n  = 1'b0;
          fail_n  = 1'b0;
          state_n = PROBE;
        end
      end
      PROBE: begin
        if (d_r[2])    state_n = BACK;
        else if (skip) d_n = d_r + 3'd1;
        else           state_n = WAIT;
      end
      WAIT: begin
        if (mem_valid) begin
          if (mem_wall) begin
            d_n     = d_r + 3'd1;
            state_n = PROBE;
          end else if (full) begin
            fail_n  = 1'b1;
            state_n = IDLE;
          end else begin
            push    = 1'b1;
            sp_n    = sp_r + SP_W'(1);
            x_n     = fwd_x;
            y_n     = fwd_y;
            d_n     = '0;
            rp_n    = '0;
            state_n = at_goal ? REPLAY : PROBE;
          end
        end
      end
      BACK: begin
        if (sp_r == '0) begin
          fail_n  = 1'b1;
          state_n = IDLE;
        end else begin
          sp_n    = sp_m1;
          x_n     = bk_x;
          y_n     = bk_y;
          d_n     = {1'b0, top} + 3'd1;
          // Popping a direction-3 entry leaves nothing to try here: keep unwinding.
          state_n = (top == 2'd3) ? BACK : PROBE;
        end
      end
      REPLAY: begin
        if (move_ready) begin
          if (rp_r == sp_m1) begin
            done_n  = 1'b1;
            state_n = IDLE;
          end else begin
            rp_n = rp_r + SP_W'(1);
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      x_r    <= '0;
      y_r    <= '0;
      d_r    <= '0;
      sp_r   <= '0;
      rp_r   <= '0;
      done_r <= 1'b0;
      fail_r <= 1'b0;
    end else begin
      state  <= state_n;
      x_r    <= x_n;
      y_r    <= y_n;
      d_r    <= d_n;
      sp_r   <= sp_n;
      rp_r   <= rp_n;
      done_r <= done_n;
      fail_r <= fail_n;
    end
  end

  // Stack contents need no reset: sp_r alone defines what is valid.
  always_ff @(posedge clk) begin
    if (push) stack[sp_r[IDX_W-1:0]] <= dir;
  end

  assign mem_rd     = (state == WAIT);
  assign mem_x      = mem_rd ? fwd_x : '0;
  assign mem_y      = mem_rd ? fwd_y : '0;
  assign move_valid = (state == REPLAY);
  assign move       = move_valid ? stack[rp_r[IDX_W-1:0]] : 2'd0;
  assign X          = x_r;
  assign Y          = y_r;
  assign busy       = (state != IDLE);
  assign done       = done_r;
  assign fail       = fail_r;

`ifdef MAZE_WALKER_STEP_CNT_EN
  logic        stepped;
  logic [15:0] step_r;

  assign stepped = ((state == WAIT) && mem_valid && !mem_wall && !full) ||
                   ((state == BACK) && (sp_r != '0));

  always_ff @(posedge clk) begin
    if (rst)                            step_r <= '0;
    else if ((state == IDLE) && start)  step_r <= '0;
    else if (stepped && (step_r != 16'hFFFF)) step_r <= step_r + 16'd1;
  end

  assign step_count = step_r;
`endif

endmodule
